key_cmd_scheduler: RTL and testbench
====================================

// Module: key_cmd_scheduler
// PURPOSE
//  Sits between the keyboard decoder's 4-bit key-code output and the VGA drawing engine.
//  Buffers key events in a small FIFO and applies each one in order: cursor moves, colour,
//  brush size and erase mode. Paint/clear requests go to the draw engine over a
//  valid/ready handshake, so the drawing resource sees one ordered command stream.
// PARAMETERS
//  FIFO_DEPTH  4   key-event FIFO entries (power of 2, >=2)
//  GRID_W      40  cursor grid width in cells
//  GRID_H      30  cursor grid height in cells
//  XW          6   cursor x width, >= clog2(GRID_W)
//  YW          5   cursor y width, >= clog2(GRID_H)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  key_evt    in   1   1-cycle strobe: key_code holds a new press
//  key_code   in   4   0 SHIFT,1 ONE,2 TWO,3 THREE,5 FIVE,6 UP,7 DOWN,8 LEFT,9 RIGHT,
//                      A SPACE,B ADD,C MINUS,D MUL,E ENTER,F WAIT
//  cmd_valid  out  1   draw command pending
//  cmd_ready  in   1   draw engine accepts command
//  cmd_op     out  2   01 PAINT, 10 CLEAR (00/11 never issued)
//  cmd_x      out  XW  command cell x
//  cmd_y      out  YW  command cell y
//  cmd_color  out  2   command colour (0 = background)
//  cmd_size   out  3   command brush size, 1..4
//  cur_x      out  XW  live cursor x
//  cur_y      out  YW  live cursor y
//  color      out  2   live colour
//  size       out  3   live brush size
//  erase      out  1   erase mode
//  fifo_count out  clog2(FIFO_DEPTH)+1  queued events
//  drop_cnt   out  8   events dropped on full FIFO, saturates at 255
//  busy       out  1   FSM not in IDLE, or fifo_count != 0
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, state IDLE, cmd_valid=0, cmd_* = 0.
//   cur_x=GRID_W/2, cur_y=GRID_H/2, color=1, size=1, erase=0, drop_cnt=0.
//   Mid-handshake reset drops cmd_valid immediately. The command is lost.
//  Push: key_evt=1 and key_code!=F -> write. key_code F is ignored.
//   Full is judged on the pre-pop count. A push when full is dropped (drop_cnt++) even if a
//   pop occurs the same cycle. A simultaneous non-full push and pop is legal; count unchanged.
//  FSM: IDLE -> EXEC -> (ISSUE | IDLE).
//   IDLE: if FIFO non-empty, pop the head into cur_code and go to EXEC.
//   EXEC (1 cycle) updates registers at cycle end:
//    UP/DOWN: y-1 / y+1, wrap 0 <-> GRID_H-1. LEFT/RIGHT: x-1 / x+1, wrap 0 <-> GRID_W-1.
//    ONE/TWO/THREE: color=1/2/3. FIVE: color=0. SHIFT: toggle erase.
//    ADD: size+1, saturate at 4. MINUS: size-1, saturate at 1.
//    MUL: cursor to (GRID_W/2, GRID_H/2).
//    SPACE: load cmd_op=01, cmd_x/y = current cursor, cmd_color = (erase ? 0 : color),
//     cmd_size=size; go to ISSUE.
//    ENTER: load cmd_op=10, other cmd_* unchanged; go to ISSUE.
//    Any other code: no effect; go to IDLE.
//  ISSUE: cmd_valid=1 with cmd_* stable until cmd_valid & cmd_ready at a clock edge, then
//   cmd_valid=0 next cycle and go to IDLE. Queued events wait. The FIFO keeps accepting.
//  Latency: key_evt at cycle N on an idle, empty block -> new cur_x/cur_y/etc visible at N+3.
//   For SPACE/ENTER, cmd_valid rises at N+3. Throughput: non-command keys 1 per 2 cycles.
//   With cmd_ready held high, a command key takes 3 cycles.
// TESTING
//  1 Reset, then RIGHT at cycle 0 -> cur_x=21 at cycle 3; cmd_valid stays 0; busy 0 at cycle 3.
//  2 cur_y=0, press UP -> cur_y=29. cur_x=39, press RIGHT -> cur_x=0.
//    ADD x5 -> size=4. MINUS x5 -> size=1.
//  3 TWO, SHIFT, SPACE with cmd_ready=0 for 10 cycles -> cmd_valid held, op=01, color=0,
//    payload stable. Raise cmd_ready -> single transfer, then cmd_valid=0.
//  4 cmd_ready=0 and a pending command; push 6 events back-to-back -> fifo_count=4,
//    drop_cnt=2, queued keys applied in order after release.
//  5 Full FIFO with push and pop in the same cycle -> push dropped, drop_cnt+1.
//    Key_code F strobes -> never queued.
//  6 Assert rst during ISSUE -> cmd_valid=0 asynchronously; all outputs at reset values;
//    FIFO empty.

Source files
------------

// File: rtl/key_cmd_if.sv
// Key-event input, draw-command handshake and live status signals shared by
// the keyboard decoder, key_cmd_scheduler and the VGA drawing engine.
interface key_cmd_if #(
    parameter int unsigned XW = 6,
    parameter int unsigned YW = 5,
    parameter int unsigned CW = 3
);
    logic          key_evt_i;
    logic [3:0]    key_code_i;
    logic          cmd_ready_i;
    logic          cmd_valid_o;
    logic [1:0]    cmd_op_o;
    logic [XW-1:0] cmd_x_o;
    logic [YW-1:0] cmd_y_o;
    logic [1:0]    cmd_color_o;
    logic [2:0]    cmd_size_o;
    logic [XW-1:0] cur_x_o;
    logic [YW-1:0] cur_y_o;
    logic [1:0]    color_o;
    logic [2:0]    size_o;
    logic          erase_o;
    logic [CW-1:0] fifo_count_o;
    logic [7:0]    drop_cnt_o;
    logic          busy_o;

    modport slave (
        input  key_evt_i, key_code_i, cmd_ready_i,
        output cmd_valid_o, cmd_op_o, cmd_x_o, cmd_y_o, cmd_color_o, cmd_size_o,
               cur_x_o, cur_y_o, color_o, size_o, erase_o,
               fifo_count_o, drop_cnt_o, busy_o
    );

    modport master (
        output key_evt_i, key_code_i, cmd_ready_i,
        input  cmd_valid_o, cmd_op_o, cmd_x_o, cmd_y_o, cmd_color_o, cmd_size_o,
               cur_x_o, cur_y_o, color_o, size_o, erase_o,
               fifo_count_o, drop_cnt_o, busy_o
    );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Queues decoded key events and applies them in order to the cursor/brush
// state, forwarding paint/clear requests to the draw engine over valid/ready.
module key_cmd_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GRID_W     = 40,
    parameter int unsigned GRID_H     = 30,
    parameter int unsigned XW         = 6,
    parameter int unsigned YW         = 5
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    key_cmd_if.slave bus
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [XW-1:0] X_MID = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_MID = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    localparam logic [3:0] K_SHIFT = 4'h0;
    localparam logic [3:0] K_ONE   = 4'h1;
    localparam logic [3:0] K_TWO   = 4'h2;
    localparam logic [3:0] K_THREE = 4'h3;
    localparam logic [3:0] K_FIVE  = 4'h5;
    localparam logic [3:0] K_UP    = 4'h6;
    localparam logic [3:0] K_DOWN  = 4'h7;
    localparam logic [3:0] K_LEFT  = 4'h8;
    localparam logic [3:0] K_RIGHT = 4'h9;
    localparam logic [3:0] K_SPACE = 4'hA;
    localparam logic [3:0] K_ADD   = 4'hB;
    localparam logic [3:0] K_MINUS = 4'hC;
    localparam logic [3:0] K_MUL   = 4'hD;
    localparam logic [3:0] K_ENTER = 4'hE;
    localparam logic [3:0] K_WAIT  = 4'hF;

    localparam logic [1:0] OP_PAINT = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic [3:0]    cur_code_q, cur_code_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic [1:0]    color_q, color_d;
    logic [2:0]    size_q, size_d;
    logic          erase_q, erase_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [1:0]    cmd_op_q, cmd_op_d;
    logic [XW-1:0] cmd_x_q, cmd_x_d;
    logic [YW-1:0] cmd_y_q, cmd_y_d;
    logic [1:0]    cmd_color_q, cmd_color_d;
    logic [2:0]    cmd_size_q, cmd_size_d;
    logic          busy_q, busy_d;

    logic push_req, fifo_full, push, pop;

    // Fullness uses the pre-pop count, so a push into a full FIFO is dropped
    // even when the FSM pops in the same cycle.
    assign push_req  = bus.key_evt_i && (bus.key_code_i != K_WAIT);
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign push      = push_req && !fifo_full;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            cur_code_q  <= '0;
            cur_x_q     <= X_MID;
            cur_y_q     <= Y_MID;
            color_q     <= 2'd1;
            size_q      <= 3'd1;
            erase_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_x_q     <= '0;
            cmd_y_q     <= '0;
            cmd_color_q <= '0;
            cmd_size_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            cur_code_q  <= cur_code_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            color_q     <= color_d;
            size_q      <= size_d;
            erase_q     <= erase_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_x_q     <= cmd_x_d;
            cmd_y_q     <= cmd_y_d;
            cmd_color_q <= cmd_color_d;
            cmd_size_q  <= cmd_size_d;
            busy_q      <= busy_d;
        end
    end

    // Event storage needs no reset: emptiness is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.key_code_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        drop_d      = drop_q;
        cur_code_d  = cur_code_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        color_d     = color_q;
        size_d      = size_q;
        erase_d     = erase_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_x_d     = cmd_x_q;
        cmd_y_d     = cmd_y_q;
        cmd_color_d = cmd_color_q;
        cmd_size_d  = cmd_size_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push_req && fifo_full && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_code_d = mem_q[rd_ptr_q];
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (cur_code_q)
                    K_UP:    cur_y_d = (cur_y_q == '0) ? Y_MAX : cur_y_q - YW'(1);
                    K_DOWN:  cur_y_d = (cur_y_q == Y_MAX) ? '0 : cur_y_q + YW'(1);
                    K_LEFT:  cur_x_d = (cur_x_q == '0) ? X_MAX : cur_x_q - XW'(1);
                    K_RIGHT: cur_x_d = (cur_x_q == X_MAX) ? '0 : cur_x_q + XW'(1);
                    K_ONE:   color_d = 2'd1;
                    K_TWO:   color_d = 2'd2;
                    K_THREE: color_d = 2'd3;
                    K_FIVE:  color_d = 2'd0;
                    K_SHIFT: erase_d = !erase_q;
                    K_ADD:   if (size_q < 3'd4) size_d = size_q + 3'd1;
                    K_MINUS: if (size_q > 3'd1) size_d = size_q - 3'd1;
                    K_MUL: begin
                        cur_x_d = X_MID;
                        cur_y_d = Y_MID;
                    end
                    K_SPACE: begin
                        cmd_op_d    = OP_PAINT;
                        cmd_x_d     = cur_x_q;
                        cmd_y_d     = cur_y_q;
                        cmd_color_d = erase_q ? 2'd0 : color_q;
                        cmd_size_d  = size_q;
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                    K_ENTER: begin
                        cmd_op_d    = OP_CLEAR;
                        cmd_valid_d = 1'b1;
                        state_d     = S_ISSUE;
                    end
                    default: ;
                endcase
            end
            S_ISSUE: begin
                if (cmd_valid_q && bus.cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    assign bus.cmd_valid_o  = cmd_valid_q;
    assign bus.cmd_op_o     = cmd_op_q;
    assign bus.cmd_x_o      = cmd_x_q;
    assign bus.cmd_y_o      = cmd_y_q;
    assign bus.cmd_color_o  = cmd_color_q;
    assign bus.cmd_size_o   = cmd_size_q;
    assign bus.cur_x_o      = cur_x_q;
    assign bus.cur_y_o      = cur_y_q;
    assign bus.color_o      = color_q;
    assign bus.size_o       = size_q;
    assign bus.erase_o      = erase_q;
    assign bus.fifo_count_o = count_q;
    assign bus.drop_cnt_o   = drop_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed and randomized checks of key_cmd_scheduler against a transaction-level
// model of the cursor/brush state and the expected draw-command stream.
module tb_key_cmd_scheduler;
    localparam int GW = 40;
    localparam int GH = 30;

    localparam logic [3:0] K_SHIFT = 4'h0;
    localparam logic [3:0] K_ONE   = 4'h1;
    localparam logic [3:0] K_TWO   = 4'h2;
    localparam logic [3:0] K_THREE = 4'h3;
    localparam logic [3:0] K_FIVE  = 4'h5;
    localparam logic [3:0] K_UP    = 4'h6;
    localparam logic [3:0] K_DOWN  = 4'h7;
    localparam logic [3:0] K_LEFT  = 4'h8;
    localparam logic [3:0] K_RIGHT = 4'h9;
    localparam logic [3:0] K_SPACE = 4'hA;
    localparam logic [3:0] K_ADD   = 4'hB;
    localparam logic [3:0] K_MINUS = 4'hC;
    localparam logic [3:0] K_MUL   = 4'hD;
    localparam logic [3:0] K_ENTER = 4'hE;
    localparam logic [3:0] K_WAIT  = 4'hF;

    typedef struct {
        int op;
        int x;
        int y;
        int color;
        int size;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy_main;
    logic rdy_rnd;
    logic rdy_rand;

    int checks   = 0;
    int failures = 0;

    int   m_x, m_y, m_col, m_size, m_erase, exp_drop;
    cmd_t mc;
    cmd_t exp_q[$];

    key_cmd_if #(.XW(6), .YW(5), .CW(3)) bus ();

    key_cmd_scheduler #(
        .FIFO_DEPTH(4), .GRID_W(40), .GRID_H(30), .XW(6), .YW(5)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.cmd_ready_i = rdy_rand ? rdy_rnd : rdy_main;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = GW / 2; m_y = GH / 2; m_col = 1; m_size = 1; m_erase = 0;
        mc = '{0, 0, 0, 0, 0};
        exp_q.delete();
        exp_drop = 0;
    endtask

    task automatic model_apply(input logic [3:0] code);
        case (code)
            K_UP:    m_y = (m_y + GH - 1) % GH;
            K_DOWN:  m_y = (m_y + 1) % GH;
            K_LEFT:  m_x = (m_x + GW - 1) % GW;
            K_RIGHT: m_x = (m_x + 1) % GW;
            K_ONE, K_TWO, K_THREE: m_col = int'(code);
            K_FIVE:  m_col = 0;
            K_SHIFT: m_erase = 1 - m_erase;
            K_ADD:   m_size = (m_size >= 4) ? 4 : m_size + 1;
            K_MINUS: m_size = (m_size <= 1) ? 1 : m_size - 1;
            K_MUL: begin m_x = GW / 2; m_y = GH / 2; end
            K_SPACE: begin
                mc = '{1, m_x, m_y, (m_erase != 0) ? 0 : m_col, m_size};
                exp_q.push_back(mc);
            end
            K_ENTER: begin
                mc.op = 2;
                exp_q.push_back(mc);
            end
            default: ;
        endcase
    endtask

    // One clock: entered and left on a falling edge; handshakes are judged just
    // before the rising edge that completes them.
    task automatic tick();
        cmd_t e;
        if (rdy_rand) rdy_rnd = 1'($urandom_range(0, 1));
        #1;
        if (bus.cmd_valid_o && bus.cmd_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_op",    32'(bus.cmd_op_o),    32'(e.op));
                chk("xfer_x",     32'(bus.cmd_x_o),     32'(e.x));
                chk("xfer_y",     32'(bus.cmd_y_o),     32'(e.y));
                chk("xfer_color", 32'(bus.cmd_color_o), 32'(e.color));
                chk("xfer_size",  32'(bus.cmd_size_o),  32'(e.size));
            end
        end
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] code);
        bus.key_evt_i  = 1'b1;
        bus.key_code_i = code;
        tick();
        bus.key_evt_i  = 1'b0;
    endtask

    task automatic push_m(input logic [3:0] code);
        if (code != K_WAIT) model_apply(code);
        push(code);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy_o || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.cmd_valid_o && n < 50) begin
            tick();
            n++;
        end
        chk("valid_timeout", 32'(bus.cmd_valid_o), 32'd1);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cur_x"}, 32'(bus.cur_x_o),      32'(m_x));
        chk({tag, "_cur_y"}, 32'(bus.cur_y_o),      32'(m_y));
        chk({tag, "_color"}, 32'(bus.color_o),      32'(m_col));
        chk({tag, "_size"},  32'(bus.size_o),       32'(m_size));
        chk({tag, "_erase"}, 32'(bus.erase_o),      32'(m_erase));
        chk({tag, "_count"}, 32'(bus.fifo_count_o), 32'd0);
        chk({tag, "_drop"},  32'(bus.drop_cnt_o),   32'(exp_drop));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"},     32'(bus.cmd_valid_o),  32'd0);
        chk({tag, "_cmd_op"},    32'(bus.cmd_op_o),     32'd0);
        chk({tag, "_cmd_x"},     32'(bus.cmd_x_o),      32'd0);
        chk({tag, "_cmd_y"},     32'(bus.cmd_y_o),      32'd0);
        chk({tag, "_cmd_color"}, 32'(bus.cmd_color_o),  32'd0);
        chk({tag, "_cmd_size"},  32'(bus.cmd_size_o),   32'd0);
        chk({tag, "_cur_x"},     32'(bus.cur_x_o),      32'd20);
        chk({tag, "_cur_y"},     32'(bus.cur_y_o),      32'd15);
        chk({tag, "_color"},     32'(bus.color_o),      32'd1);
        chk({tag, "_size"},      32'(bus.size_o),       32'd1);
        chk({tag, "_erase"},     32'(bus.erase_o),      32'd0);
        chk({tag, "_count"},     32'(bus.fifo_count_o), 32'd0);
        chk({tag, "_drop"},      32'(bus.drop_cnt_o),   32'd0);
        chk({tag, "_busy"},      32'(bus.busy_o),       32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.key_evt_i  = 1'b0;
        bus.key_code_i = 4'h0;
        rdy_main       = 1'b1;
        rdy_rnd        = 1'b0;
        rdy_rand       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // Single RIGHT on an idle block: result appears three cycles later.
        push_m(K_RIGHT);
        chk("lat_c1_x", 32'(bus.cur_x_o), 32'd20);
        tick();
        chk("lat_c2_x", 32'(bus.cur_x_o), 32'd20);
        tick();
        chk("lat_c3_x",     32'(bus.cur_x_o),     32'd21);
        chk("lat_c3_busy",  32'(bus.busy_o),      32'd0);
        chk("lat_c3_valid", 32'(bus.cmd_valid_o), 32'd0);

        // Wrap-around and size saturation.
        repeat (15) begin push_m(K_UP); wait_idle(); end
        chk("y_at_0", 32'(bus.cur_y_o), 32'd0);
        push_m(K_UP); wait_idle();
        chk("y_wrap", 32'(bus.cur_y_o), 32'd29);
        repeat (18) begin push_m(K_RIGHT); wait_idle(); end
        chk("x_at_39", 32'(bus.cur_x_o), 32'd39);
        push_m(K_RIGHT); wait_idle();
        chk("x_wrap", 32'(bus.cur_x_o), 32'd0);
        repeat (5) begin push_m(K_ADD); wait_idle(); end
        chk("size_max", 32'(bus.size_o), 32'd4);
        repeat (5) begin push_m(K_MINUS); wait_idle(); end
        chk("size_min", 32'(bus.size_o), 32'd1);
        check_state("dir");

        // Erase-mode paint held off by the draw engine.
        push_m(K_TWO);   wait_idle();
        push_m(K_SHIFT); wait_idle();
        rdy_main = 1'b0;
        push_m(K_SPACE);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(bus.cmd_valid_o), 32'd1);
            chk("hold_op",    32'(bus.cmd_op_o),    32'd1);
            chk("hold_color", 32'(bus.cmd_color_o), 32'd0);
            chk("hold_x",     32'(bus.cmd_x_o),     32'(m_x));
            chk("hold_y",     32'(bus.cmd_y_o),     32'(m_y));
            chk("hold_size",  32'(bus.cmd_size_o),  32'(m_size));
            tick();
        end
        rdy_main = 1'b1;
        tick();
        chk("after_xfer_valid", 32'(bus.cmd_valid_o), 32'd0);
        chk("after_xfer_q",     32'(exp_q.size()),     32'd0);
        push_m(K_SHIFT); wait_idle();
        check_state("hold");

        // Six pushes while a command is stalled: four queue, two drop.
        rdy_main = 1'b0;
        push_m(K_SPACE);
        wait_valid();
        push_m(K_DOWN);
        push_m(K_SPACE);
        push_m(K_RIGHT);
        push_m(K_ENTER);
        push(K_THREE);
        push(K_UP);
        exp_drop += 2;
        chk("ovf_count", 32'(bus.fifo_count_o), 32'd4);
        chk("ovf_drop",  32'(bus.drop_cnt_o),   32'(exp_drop));
        chk("ovf_valid", 32'(bus.cmd_valid_o),  32'd1);
        rdy_main = 1'b1;
        wait_idle();
        check_state("ovf");

        // Push into a full FIFO on the same cycle the head is popped.
        rdy_main = 1'b0;
        push_m(K_SPACE);
        wait_valid();
        push_m(K_ONE);
        push_m(K_TWO);
        push_m(K_FIVE);
        push_m(K_THREE);
        chk("full_count", 32'(bus.fifo_count_o), 32'd4);
        rdy_main = 1'b1;
        tick();
        chk("pp_valid", 32'(bus.cmd_valid_o),  32'd0);
        chk("pp_count", 32'(bus.fifo_count_o), 32'd4);
        push(K_ADD);
        exp_drop += 1;
        chk("pp_count_after", 32'(bus.fifo_count_o), 32'd3);
        chk("pp_drop",        32'(bus.drop_cnt_o),   32'(exp_drop));
        wait_idle();
        check_state("pp");
        for (int i = 0; i < 4; i++) begin
            push(K_WAIT);
            chk("wait_count", 32'(bus.fifo_count_o), 32'd0);
            chk("wait_busy",  32'(bus.busy_o),       32'd0);
        end
        tick();
        check_state("wait");

        // Reset while a command is being offered.
        rdy_main = 1'b0;
        push_m(K_SPACE);
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.cmd_valid_o), 32'd0);
        model_reset();
        @(negedge clk);
        check_reset("midrst");
        rst_n    = 1'b1;
        rdy_main = 1'b1;
        tick();

        // Random bursts with a randomly stalling draw engine.
        rdy_rand = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                push_m(4'($urandom_range(0, 15)));
            end
            wait_idle();
            check_state("rnd");
        end
        rdy_rand = 1'b0;
        chk("end_cmd_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
